// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: state encoding,
// word geometry and the default instruction memory depth.
package imem_loader_pkg;

  localparam int IMEM_WORDS     = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = $clog2(BYTES_PER_WORD);
  localparam int WORD_W         = 8 * BYTES_PER_WORD;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic logic is_busy(input state_t s);
    return (s == RECV) || (s == WRITE) || (s == CHECK);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream, instruction-memory write and status signals of the boot loader.
// slave = loader side, master = system/driver side.
interface imem_loader_if #(
  parameter int ADDR_W = 5
);
  logic              i_Start;
  logic [ADDR_W:0]   i_Length;
  logic              i_Byte_Valid;
  logic [7:0]        i_Byte;
  logic              o_Byte_Ready;
  logic              o_IM_WriteEn;
  logic [ADDR_W-1:0] o_IM_Addr;
  logic [31:0]       o_IM_WriteData;
  logic              o_Core_Reset;
  logic              o_Busy;
  logic              o_Done;
  logic              o_Error;

  modport master (
    output i_Start, i_Length, i_Byte_Valid, i_Byte,
    input  o_Byte_Ready, o_IM_WriteEn, o_IM_Addr, o_IM_WriteData,
    input  o_Core_Reset, o_Busy, o_Done, o_Error
  );

  modport slave (
    input  i_Start, i_Length, i_Byte_Valid, i_Byte,
    output o_Byte_Ready, o_IM_WriteEn, o_IM_Addr, o_IM_WriteData,
    output o_Core_Reset, o_Busy, o_Done, o_Error
  );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs accepted bytes little-endian into a 32-bit word; word_full marks the
// transfer that fills the top lane.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_full
);

  logic [LANE_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [WORD_W-1:0] word_q, word_d;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    if (clear) begin
      byte_cnt_d = '0;
    end else if (byte_en) begin
      word_d[{byte_cnt_q, 3'b000} +: 8] = byte_in;
      byte_cnt_d = byte_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      byte_cnt_q <= '0;
      word_q     <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
    end
  end

  assign word_full = byte_en && (byte_cnt_q == LANE_W'(BYTES_PER_WORD - 1));
  assign word      = word_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: fills instruction memory from a byte stream while holding the core
// in reset. Define LOADER_CHECKSUM_EN to add a trailing 8-bit checksum byte.
//
// state | meaning
// IDLE  | core held, waiting for i_Start
// RECV  | collecting the bytes of the current word
// WRITE | one-cycle write of the assembled word
// CHECK | waiting for the checksum byte
// DONE  | image loaded, core released
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int WORDS  = IMEM_WORDS,
  parameter int ADDR_W = 5
) (
  input logic          clk,
  input logic          reset,
  imem_loader_if.slave bus
);

`ifdef LOADER_CHECKSUM_EN
  localparam state_t LAST_NEXT = CHECK;
`else
  localparam state_t LAST_NEXT = DONE;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d, word_cnt_q, word_cnt_d, len_sat;
  logic              byte_ready_q, we_q, busy_q, done_q, core_reset_q;
  logic              start_ok, byte_xfer, asm_en, word_full;
  logic [WORD_W-1:0] word;

  assign len_sat   = (bus.i_Length > (ADDR_W+1)'(WORDS)) ? (ADDR_W+1)'(WORDS) : bus.i_Length;
  assign start_ok  = bus.i_Start && ((state_q == IDLE) || (state_q == DONE));
  assign byte_xfer = bus.i_Byte_Valid && byte_ready_q;
  assign asm_en    = byte_xfer && (state_q == RECV);

  word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_ok),
    .byte_en   (asm_en),
    .byte_in   (bus.i_Byte),
    .word      (word),
    .word_full (word_full)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.i_Start) begin
          len_d      = len_sat;
          word_cnt_d = '0;
          state_d    = (len_sat == '0) ? LAST_NEXT : RECV;
        end
      end
      RECV: begin
        if (word_full) state_d = WRITE;
      end
      WRITE: begin
        word_cnt_d = word_cnt_q + 1'b1;
        state_d    = (word_cnt_d == len_q) ? LAST_NEXT : RECV;
      end
      CHECK: begin
        if (byte_xfer) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      word_cnt_q   <= '0;
      byte_ready_q <= 1'b0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_cnt_q   <= word_cnt_d;
      byte_ready_q <= (state_d == RECV) || (state_d == CHECK);
      we_q         <= (state_d == WRITE);
      busy_q       <= is_busy(state_d);
      done_q       <= (state_d == DONE);
      core_reset_q <= (state_d != DONE);
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       error_q, error_d;

  always_comb begin
    sum_d   = sum_q;
    error_d = error_q;
    if (start_ok) begin
      sum_d   = '0;
      error_d = 1'b0;
    end else if (asm_en) begin
      sum_d = sum_q + bus.i_Byte;
    end else if (byte_xfer && (state_q == CHECK)) begin
      error_d = (bus.i_Byte != sum_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sum_q   <= '0;
      error_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      error_q <= error_d;
    end
  end

  assign bus.o_Error = error_q;
`else
  assign bus.o_Error = 1'b0;
`endif

  assign bus.o_Byte_Ready   = byte_ready_q;
  assign bus.o_IM_WriteEn   = we_q;
  assign bus.o_IM_Addr      = we_q ? word_cnt_q[ADDR_W-1:0] : '0;
  assign bus.o_IM_WriteData = we_q ? word : '0;
  assign bus.o_Core_Reset   = core_reset_q;
  assign bus.o_Busy         = busy_q;
  assign bus.o_Done         = done_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot loader that fills the instruction memory before the core runs. It receives a byte stream over a valid/ready handshake and packs each four bytes into a little-endian 32-bit word. Each word goes out on a single-port write interface into the instruction memory array. The loader holds the core's active-high reset until the load completes, so the instruction memory's read port sees only a fully written image.

## Interface
Parameters:
- WORDS, 32, instruction memory depth in words.
- ADDR_W, 5, word address width; equals log2(WORDS).

Ports:
- clk  in  1  rising-edge clock, shared with the core.
- reset  in  1  synchronous, active-low reset.
- i_Start  in  1  one-cycle pulse that begins a load.
- i_Length  in  ADDR_W+1  number of words to load, range 0..WORDS; latched on an accepted i_Start.
- i_Byte_Valid  in  1  an input byte is present.
- i_Byte  in  8  input byte.
- o_Byte_Ready  out  1  loader accepts a byte this cycle.
- o_IM_WriteEn  out  1  instruction memory write strobe.
- o_IM_Addr  out  ADDR_W  word address of the write.
- o_IM_WriteData  out  32  word being written.
- o_Core_Reset  out  1  active-high hold for the core; 1 = core held in reset.
- o_Busy  out  1  a load is in progress.
- o_Done  out  1  the last load completed.
- o_Error  out  1  checksum mismatch on the last load.

## Operation
- States: IDLE, RECV, WRITE, CHECK (only when checksum is compiled in), DONE.
- IDLE:
  - o_Core_Reset=1, all other outputs 0.
  - i_Start moves to RECV. byte_cnt, word_cnt, sum and o_Error clear, and i_Length is latched.
  - If i_Length=0, i_Start moves directly to DONE, or to CHECK when checksum is compiled in.
- RECV:
  - o_Byte_Ready=1. A byte transfers when i_Byte_Valid && o_Byte_Ready.
  - The byte goes into lane byte_cnt of the word: lane 0 is [7:0], lane 3 is [31:24].
  - byte_cnt increments modulo 4. The transfer that fills lane 3 moves to WRITE.
- WRITE:
  - Lasts exactly one cycle with o_Byte_Ready=0, o_IM_WriteEn=1, o_IM_Addr=word_cnt, o_IM_WriteData=assembled word.
  - word_cnt increments.
  - If word_cnt was length-1, move to CHECK (or DONE when checksum is compiled out); otherwise return to RECV.
- DONE:
  - o_Done=1, o_Core_Reset=0, o_Busy=0.
  - i_Start in DONE starts a new load and reasserts o_Core_Reset in the next cycle.
- o_Busy=1 in RECV, WRITE and CHECK. i_Start is ignored in those states.
- i_Length values above WORDS saturate to WORDS.
- Reset mid-load returns to IDLE with o_Core_Reset=1. Words already written stay in memory, and there is no further write.
- i_Byte is ignored whenever o_Byte_Ready=0.

## Timing
- Reset values: o_Core_Reset=1; every other output 0; state IDLE.
- i_Start sampled at cycle T gives o_Byte_Ready=1 and o_Busy=1 at T+1.
- Fourth byte accepted at cycle N:
  - o_IM_WriteEn=1 at N+1, with o_Byte_Ready=0 at N+1.
  - o_Byte_Ready=1 again at N+2.
- Minimum 5 cycles per word.
- Last write at cycle W gives o_Done=1 and o_Core_Reset=0 at W+1 when checksum is compiled out.
- All outputs are registered or decoded from the registered state; there is no combinational path from i_Byte_Valid to any output.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - sum is an 8-bit running total, modulo 256, of every data byte.
  - After the last word the loader enters CHECK, raises o_Byte_Ready and accepts one further byte.
  - If that byte differs from sum, o_Error=1. The loader then goes to DONE; o_Error stays 1 until the next accepted i_Start.
  - The core is released regardless of o_Error. System logic gates the release on o_Error if needed.
- LOADER_CHECKSUM_EN undefined: no CHECK state, no sum register, o_Error tied to 0.

## Structure
- Shared package holds:
  - state encoding constants IDLE/RECV/WRITE/CHECK/DONE;
  - BYTES_PER_WORD=4;
  - default IMEM_WORDS=32, shared with the instruction memory depth.
- One sub-module, word_assembler: byte lane register, byte_cnt and a word_full flag. The FSM, word counter and checksum stay in imem_loader.

## Test plan
- Reset with reset=0 for 2 cycles: o_Core_Reset=1, o_Busy=0, o_Done=0, o_Byte_Ready=0.
- Start with i_Length=1, bytes 0x93,0x00,0x50,0x00 sent back-to-back: one write with Addr=0, Data=0x00500093 one cycle after the fourth byte; o_Done=1 and o_Core_Reset=0 on the next cycle.
- i_Length=32, random bytes with random valid gaps: exactly 32 writes at addresses 0..31 in order; byte and word contents match a model; o_Byte_Ready is low on every write cycle.
- i_Start pulsed mid-load; then reset=0 after word 2 of 4:
  - mid-load i_Start has no effect;
  - after the reset, state is IDLE with o_Core_Reset=1 and no further writes;
  - a following i_Start reloads from address 0.
- With LOADER_CHECKSUM_EN, i_Length=1, bytes 0x01,0x02,0x03,0x04:
  - checksum byte 0x0A gives o_Error=0;
  - a rerun with checksum byte 0x0B gives o_Error=1 and o_Done=1.
- i_Length=0: no writes; o_Done=1 at T+1 (checksum compiled out), or after one checksum byte 0x00 (checksum compiled in).
